// File: rtl/rx_adder_arbiter_pkg.sv
// Shared constants for the two-requester adder arbiter: FSM encoding, requester IDs, default width.
package rx_adder_arbiter_pkg;
  localparam int N_DEF = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/add.sv
// Plain N-bit ripple adder with carry in/out.
module add #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);
  assign {c_out, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c_in};
endmodule

// File: rtl/rx_adder_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_pick2
  import rx_adder_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);
  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) grant_id = ~last;
    else if (req_b)     grant_id = REQ_B;
    else                grant_id = REQ_A;
  end
endmodule

// File: rtl/rx_adder_arbiter.sv
// Shares one adder between requesters A and B over 4-phase req/ack, round-robin arbitration.
// Build option RX_ADDER_ARBITER_SAT_EN: saturate the result to all ones on carry out.
module rx_adder_arbiter
  import rx_adder_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         req_a,
  input  logic [N-1:0] x_a,
  input  logic [N-1:0] y_a,
  output logic         ack_a,
  output logic [N-1:0] s_a,
  output logic         ow_a,
  input  logic         req_b,
  input  logic [N-1:0] x_b,
  input  logic [N-1:0] y_b,
  output logic         ack_b,
  output logic [N-1:0] s_b,
  output logic         ow_b,
  output logic         busy
);
  logic [1:0]   state;
  logic         last, grant;
  logic [N-1:0] xr, yr, sum, res;
  logic         carry, gv, gid, req_g;

  rr_pick2 u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last        (last),
    .grant_valid (gv),
    .grant_id    (gid)
  );

  // Operands only ever come from the captured registers, never the ports.
  add #(.N(N)) u_add (
    .x     (xr),
    .y     (yr),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (carry)
  );

`ifdef RX_ADDER_ARBITER_SAT_EN
  assign res = carry ? {N{1'b1}} : sum;
`else
  assign res = sum;
`endif

  assign req_g = (grant == REQ_B) ? req_b : req_a;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      last  <= REQ_B;
      grant <= REQ_A;
      xr    <= '0;
      yr    <= '0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      s_a   <= '0;
      s_b   <= '0;
      ow_a  <= 1'b0;
      ow_b  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gv) begin
          grant <= gid;
          xr    <= (gid == REQ_B) ? x_b : x_a;
          yr    <= (gid == REQ_B) ? y_b : y_a;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          if (grant == REQ_B) begin
            s_b   <= res;
            ow_b  <= carry;
            ack_b <= 1'b1;
          end else begin
            s_a   <= res;
            ow_a  <= carry;
            ack_a <= 1'b1;
          end
          last  <= grant;
          state <= WAIT;
        end
        WAIT: if (!req_g) begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_adder_arbiter.sv
// Self-checking bench for rx_adder_arbiter: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_rx_adder_arbiter;
  logic       clock = 1'b0;
  logic       reset_;
  logic       req_a, req_b, ack_a, ack_b, ow_a, ow_b, busy;
  logic [7:0] x_a, y_a, x_b, y_b, s_a, s_b;

  int n_chk = 0;
  int n_fail = 0;

  // Model: result registers per requester and who was served last.
  logic [7:0] exp_s  [2];
  logic       exp_ow [2];
  logic [7:0] opx [2];
  logic [7:0] opy [2];
  bit         last_m;

  always #5 clock = ~clock;

  rx_adder_arbiter #(.N(8)) dut (
    .clock (clock), .reset_ (reset_),
    .req_a (req_a), .x_a (x_a), .y_a (y_a), .ack_a (ack_a), .s_a (s_a), .ow_a (ow_a),
    .req_b (req_b), .x_b (x_b), .y_b (y_b), .ack_b (ack_b), .s_b (s_b), .ow_b (ow_b),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_add(input logic [7:0] x, input logic [7:0] y);
    int t;
    t = int'(x) + int'(y);
`ifdef RX_ADDER_ARBITER_SAT_EN
    if (t > 255) return {1'b1, 8'hFF};
`endif
    return {t >= 256, 8'(t % 256)};
  endfunction

  function automatic logic ack_of(input bit id);
    return id ? ack_b : ack_a;
  endfunction

  function automatic logic [7:0] s_of(input bit id);
    return id ? s_b : s_a;
  endfunction

  function automatic logic ow_of(input bit id);
    return id ? ow_b : ow_a;
  endfunction

  task automatic model_reset();
    exp_s[0] = 0; exp_s[1] = 0; exp_ow[0] = 0; exp_ow[1] = 0; last_m = 1'b1;
  endtask

  task automatic await_ack(input bit id, input logic lvl, output int c);
    bit hit = 0;
    c = 0;
    while (!hit && c < 20) begin
      @(negedge clock);
      c++;
      hit = (ack_of(id) == lvl);
    end
    if (!hit) check($sformatf("timeout_ack%0d_%0d", id, lvl), 0, 1);
  endtask

  task automatic serve_one(input bit id);
    int c;
    logic [8:0] r;
    await_ack(id, 1'b1, c);
    check($sformatf("lat_ack%0d", id), c, 2);
    r = model_add(opx[id], opy[id]);
    exp_s[id] = r[7:0];
    exp_ow[id] = r[8];
    check($sformatf("s%0d", id), s_of(id), exp_s[id]);
    check($sformatf("ow%0d", id), ow_of(id), exp_ow[id]);
    check($sformatf("other_ack_low%0d", id), ack_of(~id), 0);
    check($sformatf("other_s_held%0d", id), s_of(~id), exp_s[~id]);
    check("busy_hi", busy, 1);
    if (id) req_b = 0; else req_a = 0;
    await_ack(id, 1'b0, c);
    check($sformatf("rel_ack%0d", id), c, 1);
    check("busy_lo", busy, 0);
    check($sformatf("other_ack_still_low%0d", id), ack_of(~id), 0);
    last_m = id;
  endtask

  // Call at a negedge with the arbiter idle; serves both requesters if both raised.
  task automatic serve_pair(input bit ra, input bit rb, input logic [7:0] xa, input logic [7:0] ya,
                            input logic [7:0] xb, input logic [7:0] yb, output bit first);
    first = (ra && rb) ? ~last_m : rb;
    opx[0] = xa; opy[0] = ya; opx[1] = xb; opy[1] = yb;
    x_a = xa; y_a = ya; x_b = xb; y_b = yb;
    req_a = ra; req_b = rb;
    serve_one(first);
    if (ra && rb) serve_one(~first);
  endtask

  initial begin
    bit f;
    int c;
    reset_ = 0; req_a = 0; req_b = 0; x_a = 0; y_a = 0; x_b = 0; y_b = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_ = 1;
    @(negedge clock);
    check("rst_ack_a", ack_a, 0); check("rst_ack_b", ack_b, 0);
    check("rst_s_a", s_a, 0);     check("rst_s_b", s_b, 0);
    check("rst_ow", {ow_a, ow_b}, 0); check("rst_busy", busy, 0);

    // Basic: 10+20 with exact edge timing.
    x_a = 10; y_a = 20; req_a = 1;
    @(negedge clock);
    check("t1_ack_early", ack_a, 0); check("t1_busy_grant", busy, 1);
    @(negedge clock);
    check("t1_ack", ack_a, 1); check("t1_s", s_a, 30); check("t1_ow", ow_a, 0); check("t1_busy", busy, 1);
    req_a = 0;
    @(negedge clock);
    check("t1_ack_rel", ack_a, 0); check("t1_busy_rel", busy, 0);
    exp_s[0] = 30; exp_ow[0] = 0; last_m = 0;

    // Overflow on B.
    serve_pair(0, 1, 0, 0, 200, 100, f);
`ifdef RX_ADDER_ARBITER_SAT_EN
    check("ovf_s_b", s_b, 255);
`else
    check("ovf_s_b", s_b, 44);
`endif
    check("ovf_ow_b", ow_b, 1);

    // Round robin: tie -> A, single A, tie -> B.
    serve_pair(1, 1, 1, 2, 3, 4, f);    check("rr_first_a", f, 0);
    serve_pair(1, 0, 7, 8, 0, 0, f);    check("rr_single_a", f, 0);
    serve_pair(1, 1, 9, 9, 50, 60, f);  check("rr_first_b", f, 1);

    // B rises while A in WAIT: must wait for A's release.
    opx[0] = 33; opy[0] = 44; x_a = 33; y_a = 44; req_a = 1;
    await_ack(0, 1'b1, c);
    exp_s[0] = 77; exp_ow[0] = 0;
    opx[1] = 1; opy[1] = 1; x_b = 1; y_b = 1; req_b = 1;
    repeat (3) @(negedge clock);
    check("wait_b_blocked", ack_b, 0); check("wait_a_held", ack_a, 1);
    req_a = 0;
    await_ack(0, 1'b0, c);
    last_m = 0;
    serve_one(1);
    check("wait_s_a_kept", s_a, 77);

    // Operand capture: x_a changes one cycle after grant.
    x_a = 5; y_a = 7; req_a = 1;
    @(negedge clock);
    x_a = 0;
    @(negedge clock);
    check("cap_ack", ack_a, 1); check("cap_s", s_a, 12);
    req_a = 0;
    await_ack(0, 1'b0, c);
    exp_s[0] = 12; exp_ow[0] = 0; last_m = 0;

    // req drops during CALC: ack still pulses for one cycle.
    x_a = 100; y_a = 1; req_a = 1;
    @(negedge clock);
    req_a = 0;
    @(negedge clock);
    check("viol_ack_pulse", ack_a, 1); check("viol_s", s_a, 101);
    @(negedge clock);
    check("viol_ack_clr", ack_a, 0); check("viol_busy", busy, 0);
    exp_s[0] = 101; exp_ow[0] = 0; last_m = 0;

    // Asynchronous reset in WAIT.
    x_a = 3; y_a = 4; req_a = 1;
    await_ack(0, 1'b1, c);
    reset_ = 0;
    #1;
    check("arst_ack_a", ack_a, 0); check("arst_s_a", s_a, 0); check("arst_busy", busy, 0);
    check("arst_s_b", s_b, 0);
    req_a = 0;
    model_reset();
    @(negedge clock);
    reset_ = 1;
    @(negedge clock);
    serve_pair(0, 1, 0, 0, 17, 25, f);

    // Randomized transactions against the model.
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(1, 3);
      serve_pair(r[0], r[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), f);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
